// File: rtl/down_clocking_pkg.sv
// Shared constants for the programmable clock divider.
package down_clocking_pkg;

  // Default divisor/high-count width in bits.
  localparam int DEFAULT_W  = 16;
  // Default number of independent divider channels.
  localparam int DEFAULT_CH = 2;
  // Divisors below this value pass i_clk straight through.
  localparam int BYPASS_DIV = 2;

endpackage : down_clocking_pkg

// File: rtl/down_clocking_ch.sv
// One divider channel: programmable period and high phase, with settings
// that take effect only at a period boundary so o_clk never glitches.
module down_clocking_ch
  import down_clocking_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_divisor,
  input  logic [W-1:0] i_high,
  output logic         o_clk,
  output logic         o_tick,
  output logic         o_pend
);

  // Active settings, pending settings and the period counter.
  logic [W-1:0] div_q;
  logic [W-1:0] high_q;
  logic [W-1:0] div_p;
  logic [W-1:0] high_p;
  logic [W-1:0] ct;
  logic         pend;

  // run_q: the channel counted during the previous cycle. Without it a
  // re-enabled channel could not tell "held at 0" from "period started".
  logic         run_q;
  logic         byp_q;
  logic         clk_q;
  logic         tick_q;

  // Next-state values shared by the counter and the output flops.
  logic         apply;
  logic [W-1:0] div_n;
  logic [W-1:0] high_n;
  logic [W-1:0] ct_n;
  logic         byp_n;
  logic         run_n;

  // Decide whether pending settings apply, and where the counter goes next.
  always_comb begin
    // NOTE: every signal gets a value before any branch, so no path can
    // leave one unassigned and infer a latch.
    apply  = 1'b0;
    div_n  = div_q;
    high_n = high_q;
    ct_n   = '0;
    byp_n  = 1'b0;
    run_n  = 1'b0;

    // Pending settings wait for the period boundary unless the channel is
    // idle or bypassed, in which case there is no period to protect.
    apply = pend && (!i_en || (div_q < W'(BYPASS_DIV)) || (ct == div_q - W'(1)));

    if (apply) begin
      div_n  = div_p;
      high_n = high_p;
    end

    byp_n = i_en && (div_n < W'(BYPASS_DIV));
    run_n = i_en && !byp_n;

    // The counter restarts at 0 on disable, apply, bypass and the first
    // enabled cycle; otherwise it walks 0..div_q-1 and wraps.
    if (!i_en || apply || !run_q) begin
      ct_n = '0;
    end else if (ct == div_q - W'(1)) begin
      ct_n = '0;
    end else begin
      ct_n = ct + W'(1);
    end
  end

  // Channel state and registered outputs, all computed from next-state
  // values so the outputs line up with the counter they describe.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_q  <= '0;
      high_q <= '0;
      div_p  <= '0;
      high_p <= '0;
      ct     <= '0;
      pend   <= 1'b0;
      run_q  <= 1'b0;
      byp_q  <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here, so the apply decision above
      // sees the old pending values even when a new load lands this edge.
      if (i_load) begin
        div_p  <= i_divisor;
        high_p <= i_high;
      end
      pend   <= i_load || (pend && !apply);
      div_q  <= div_n;
      high_q <= high_n;
      ct     <= ct_n;
      run_q  <= run_n;
      byp_q  <= byp_n;
      clk_q  <= run_n && (ct_n < high_n);
      tick_q <= byp_n || (run_n && (ct_n == '0));
    end
  end

  // Bypass passes the input clock through; otherwise the output is a flop.
  assign o_clk  = byp_q ? i_clk : clk_q;
  assign o_tick = tick_q;
  assign o_pend = pend;

endmodule : down_clocking_ch

// File: rtl/down_clocking_prog.sv
// Multi-channel programmable clock divider: slices the packed buses and
// hands each slice to an independent channel.
module down_clocking_prog
  import down_clocking_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CH = DEFAULT_CH
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [CH-1:0]   i_en,
  input  logic [CH-1:0]   i_load,
  input  logic [CH*W-1:0] i_divisor,
  input  logic [CH*W-1:0] i_high,
  output logic [CH-1:0]   o_clk,
  output logic [CH-1:0]   o_tick,
  output logic [CH-1:0]   o_pend
);

  // One divider per channel; channel k owns bits [k*W +: W] of each bus.
  for (genvar k = 0; k < CH; k++) begin : g_ch
    down_clocking_ch #(
      .W (W)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_en      (i_en[k]),
      .i_load    (i_load[k]),
      .i_divisor (i_divisor[k*W +: W]),
      .i_high    (i_high[k*W +: W]),
      .o_clk     (o_clk[k]),
      .o_tick    (o_tick[k]),
      .o_pend    (o_pend[k])
    );
  end

endmodule : down_clocking_prog

// File: tb/tb_down_clocking_prog.sv
// Directed bench for the programmable clock divider.
module tb_down_clocking_prog;

  localparam int W  = 16;
  localparam int CH = 2;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [CH-1:0]   i_en;
  logic [CH-1:0]   i_load;
  logic [CH*W-1:0] i_divisor;
  logic [CH*W-1:0] i_high;
  logic [CH-1:0]   o_clk;
  logic [CH-1:0]   o_tick;
  logic [CH-1:0]   o_pend;

  int n_vec = 0;
  int n_err = 0;

  down_clocking_prog #(.W(W), .CH(CH)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_load    (i_load),
    .i_divisor (i_divisor),
    .i_high    (i_high),
    .o_clk     (o_clk),
    .o_tick    (o_tick),
    .o_pend    (o_pend)
  );

  always #5 i_clk = ~i_clk;

  // Reference waveform at cycle k of a period-d, high-h divider.
  function automatic logic m_clk(int k, int d, int h);
    return (k % d) < h;
  endfunction

  function automatic logic m_tick(int k, int d);
    return (k % d) == 0;
  endfunction

  // Advance one clock; sample and drive 2 time units after the rising edge.
  task automatic step();
    @(posedge i_clk);
    #2;
  endtask

  task automatic load_ch(input int ch, input int d, input int h);
    i_divisor[ch*W +: W] = W'(d);
    i_high[ch*W +: W]    = W'(h);
    i_load[ch]           = 1'b1;
    step();
    i_load[ch]           = 1'b0;
  endtask

  // Step until the channel's pending flag clears; ends on the apply cycle.
  task automatic wait_apply(input int ch);
    for (int i = 0; i < 32 && o_pend[ch] === 1'b1; i++) step();
    n_vec++;
    if (o_pend[ch] !== 1'b0) begin
      n_err++;
      $display("FAIL apply_timeout ch%0d: pend=%b want 0", ch, o_pend[ch]);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b0; i_en = '0; i_load = '0; i_divisor = '0; i_high = '0;
    #2;
    n_vec++;
    if ({o_clk, o_tick, o_pend} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got clk=%b tick=%b pend=%b want all 0", o_clk, o_tick, o_pend);
    end
    #20;
    i_rst = 1'b1;
    i_en  = 2'b11;
    step();
    n_vec++;
    if (o_clk !== 2'b11 || o_tick !== 2'b11 || o_pend !== 2'b00) begin
      n_err++;
      $display("FAIL reset_bypass_high: got clk=%b tick=%b pend=%b want 11 11 00", o_clk, o_tick, o_pend);
    end
    #5;
    n_vec++;
    if (o_clk !== 2'b00 || o_tick !== 2'b11) begin
      n_err++;
      $display("FAIL reset_bypass_low: got clk=%b tick=%b want 00 11", o_clk, o_tick);
    end
  endtask

  task automatic test_basic();
    load_ch(0, 6, 3);
    n_vec++;
    if (o_pend[0] !== 1'b1) begin
      n_err++;
      $display("FAIL basic_pend: got %b want 1", o_pend[0]);
    end
    wait_apply(0);
    for (int k = 0; k < 18; k++) begin
      n_vec++;
      if (o_clk[0] !== m_clk(k, 6, 3) || o_tick[0] !== m_tick(k, 6)) begin
        n_err++;
        $display("FAIL basic_d6h3 k=%0d: got clk=%b tick=%b want clk=%b tick=%b",
                 k, o_clk[0], o_tick[0], m_clk(k, 6, 3), m_tick(k, 6));
      end
      step();
    end
  endtask

  task automatic test_change();
    step();
    step();
    i_divisor[0 +: W] = W'(5);
    i_high[0 +: W]    = W'(2);
    i_load[0]         = 1'b1;
    step();
    i_load[0]         = 1'b0;
    for (int k = 3; k < 6; k++) begin
      n_vec++;
      if (o_pend[0] !== 1'b1 || o_clk[0] !== m_clk(k, 6, 3) || o_tick[0] !== 1'b0) begin
        n_err++;
        $display("FAIL change_old_period ct=%0d: got pend=%b clk=%b tick=%b want 1 %b 0",
                 k, o_pend[0], o_clk[0], o_tick[0], m_clk(k, 6, 3));
      end
      step();
    end
    for (int k = 0; k < 15; k++) begin
      n_vec++;
      if (o_pend[0] !== 1'b0 || o_clk[0] !== m_clk(k, 5, 2) || o_tick[0] !== m_tick(k, 5)) begin
        n_err++;
        $display("FAIL change_d5h2 k=%0d: got pend=%b clk=%b tick=%b want 0 %b %b",
                 k, o_pend[0], o_clk[0], o_tick[0], m_clk(k, 5, 2), m_tick(k, 5));
      end
      step();
    end
  endtask

  task automatic test_bypass_const();
    load_ch(0, 1, 0);
    wait_apply(0);
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (o_clk[0] !== 1'b1 || o_tick[0] !== 1'b1) begin
        n_err++;
        $display("FAIL bypass_high k=%0d: got clk=%b tick=%b want 1 1", k, o_clk[0], o_tick[0]);
      end
      #5;
      n_vec++;
      if (o_clk[0] !== 1'b0 || o_tick[0] !== 1'b1) begin
        n_err++;
        $display("FAIL bypass_low k=%0d: got clk=%b tick=%b want 0 1", k, o_clk[0], o_tick[0]);
      end
      step();
    end
    load_ch(0, 4, 0);
    wait_apply(0);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (o_clk[0] !== 1'b0 || o_tick[0] !== m_tick(k, 4)) begin
        n_err++;
        $display("FAIL const_low k=%0d: got clk=%b tick=%b want 0 %b", k, o_clk[0], o_tick[0], m_tick(k, 4));
      end
      step();
    end
    load_ch(0, 4, 9);
    wait_apply(0);
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (o_clk[0] !== 1'b1 || o_tick[0] !== m_tick(k, 4)) begin
        n_err++;
        $display("FAIL const_high k=%0d: got clk=%b tick=%b want 1 %b", k, o_clk[0], o_tick[0], m_tick(k, 4));
      end
      step();
    end
  endtask

  task automatic test_two_channels();
    i_en = 2'b00;
    i_divisor = {W'(7), W'(4)};
    i_high    = {W'(3), W'(2)};
    i_load    = 2'b11;
    step();
    i_load    = 2'b00;
    step();
    n_vec++;
    if (o_clk !== 2'b00 || o_tick !== 2'b00 || o_pend !== 2'b00) begin
      n_err++;
      $display("FAIL two_ch_idle: got clk=%b tick=%b pend=%b want 00 00 00", o_clk, o_tick, o_pend);
    end
    i_en = 2'b11;
    step();
    for (int k = 0; k < 56; k++) begin
      n_vec++;
      if (o_clk[0] !== m_clk(k, 4, 2) || o_tick[0] !== m_tick(k, 4)) begin
        n_err++;
        $display("FAIL two_ch_ch0 k=%0d: got clk=%b tick=%b want %b %b",
                 k, o_clk[0], o_tick[0], m_clk(k, 4, 2), m_tick(k, 4));
      end
      n_vec++;
      if (o_clk[1] !== m_clk(k, 7, 3) || o_tick[1] !== m_tick(k, 7)) begin
        n_err++;
        $display("FAIL two_ch_ch1 k=%0d: got clk=%b tick=%b want %b %b",
                 k, o_clk[1], o_tick[1], m_clk(k, 7, 3), m_tick(k, 7));
      end
      n_vec++;
      if ((o_tick === 2'b11) !== ((k % 28) == 0)) begin
        n_err++;
        $display("FAIL two_ch_coincide k=%0d: got tick=%b want both=%b", k, o_tick, (k % 28) == 0);
      end
      step();
    end
  endtask

  task automatic test_enable();
    load_ch(0, 8, 4);
    wait_apply(0);
    step(); step(); step();
    n_vec++;
    if (o_clk[0] !== 1'b1 || o_tick[0] !== 1'b0) begin
      n_err++;
      $display("FAIL enable_ct3: got clk=%b tick=%b want 1 0", o_clk[0], o_tick[0]);
    end
    i_en[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      n_vec++;
      if (o_clk[0] !== 1'b0 || o_tick[0] !== 1'b0) begin
        n_err++;
        $display("FAIL enable_off k=%0d: got clk=%b tick=%b want 0 0", k, o_clk[0], o_tick[0]);
      end
    end
    i_en[0] = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      n_vec++;
      if (o_clk[0] !== m_clk(k, 8, 4) || o_tick[0] !== m_tick(k, 8)) begin
        n_err++;
        $display("FAIL enable_restart k=%0d: got clk=%b tick=%b want %b %b",
                 k, o_clk[0], o_tick[0], m_clk(k, 8, 4), m_tick(k, 8));
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    load_ch(0, 3, 1);
    n_vec++;
    if (o_pend[0] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_pend: got %b want 1", o_pend[0]);
    end
    #1;
    i_rst = 1'b0;
    #1;
    n_vec++;
    if ({o_clk, o_tick, o_pend} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_async: got clk=%b tick=%b pend=%b want all 0", o_clk, o_tick, o_pend);
    end
    step();
    n_vec++;
    if ({o_clk, o_tick, o_pend} !== '0) begin
      n_err++;
      $display("FAIL rst_mid_hold: got clk=%b tick=%b pend=%b want all 0", o_clk, o_tick, o_pend);
    end
    i_rst = 1'b1;
    step();
    n_vec++;
    if (o_clk !== 2'b11 || o_tick !== 2'b11 || o_pend !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_bypass_high: got clk=%b tick=%b pend=%b want 11 11 00", o_clk, o_tick, o_pend);
    end
    #5;
    n_vec++;
    if (o_clk !== 2'b00) begin
      n_err++;
      $display("FAIL rst_mid_bypass_low: got clk=%b want 00", o_clk);
    end
    step();
    n_vec++;
    if (o_pend !== 2'b00 || o_tick !== 2'b11) begin
      n_err++;
      $display("FAIL rst_mid_discard: got pend=%b tick=%b want 00 11", o_pend, o_tick);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_change();
    test_bypass_const();
    test_two_channels();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_down_clocking_prog
